frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Shares the single-port cube frame-buffer RAM between two requesters: the USB command path, which issues chunk writes, and the panel scan engine, which issues refresh reads. Chunk writes are queued in a small FIFO so that the USB side never waits on the RAM. Refresh reads have priority, and a starvation guard ensures queued writes still drain. The block sits between the USB controller outputs (panel/row/chunk address, chunk data, write strobe) and the frame-buffer RAM.

## Interface
Parameters:
- DATA_WIDTH, 32, chunk width in bits
- FIFO_DEPTH, 4, number of write-queue entries (power of two, at least 2)
- STARVE_LIMIT, 8, number of consecutive read wins with writes pending before one write is forced

Ports:
- clk  input  1  system clock; one clock domain only
- reset  input  1  asynchronous, active-high reset
- wr_req  input  1  one-cycle chunk-write strobe from the USB controller
- wr_panel_addr  input  2  panel address of the chunk
- wr_row_addr  input  4  row address of the chunk
- wr_chunk_addr  input  4  chunk address within the row
- wr_data  input  DATA_WIDTH  chunk payload
- wr_full  output  1  write queue holds FIFO_DEPTH entries
- wr_overflow  output  1  sticky flag: a write was dropped
- rd_req  input  1  scan engine read request; held until granted
- rd_addr  input  10  read address {panel, row, chunk}
- rd_grant  output  1  read issued to the RAM this cycle
- rd_valid  output  1  rd_data is valid
- rd_data  output  DATA_WIDTH  read data
- ram_en  output  1  RAM access this cycle
- ram_we  output  1  the RAM access is a write
- ram_addr  output  10  RAM address
- ram_wdata  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  synchronous RAM read data, valid one cycle after the access

## Operation
- **Write address:** formed as {wr_panel_addr, wr_row_addr, wr_chunk_addr}.
- **Push:** a wr_req is pushed with its address and data when the queue is not full, or when it is full and a pop occurs in the same cycle.
- **Drop:** otherwise the request is dropped and wr_overflow is set. wr_overflow clears only on reset.
- **Arbitration, evaluated every cycle:**
  - Forced write: if the queue is non-empty and starve_cnt equals STARVE_LIMIT, the queue head is written. rd_grant stays 0 even if rd_req is high.
  - Read: else if rd_req is high, the read is granted (rd_grant=1, ram_en=1, ram_we=0, ram_addr=rd_addr).
  - Write: else if the queue is non-empty, the head is written (ram_en=1, ram_we=1, head address and data) and popped.
  - Otherwise the RAM is idle and all ram_* outputs are 0.
- **starve_cnt:**
  - Increments, saturating at STARVE_LIMIT, on each read grant while the queue is non-empty.
  - Clears on any write grant or whenever the queue is empty.
- **FSM state**, registered and reflecting the last grant:
  - States: IDLE, READ, WRITE, FORCED_WRITE.
  - The state is used for status and debug only; the grant logic depends solely on the current inputs, starve_cnt and the queue.
- **Coherence:** reads are not ordered against queued writes. A read of an address still held in the queue returns the RAM contents, which is the old data.
- **wr_full:** equals (count == FIFO_DEPTH), registered, and updates the cycle after the push or pop.

## Timing
- **Grant path:** rd_grant and all ram_* outputs are combinational from the current inputs and state (zero-cycle grant).
- **Read return:** rd_valid is rd_grant delayed by one cycle. rd_data = ram_rdata when rd_valid=1, otherwise 0.
- **Write latency:** a write pushed in cycle N can be issued to the RAM no earlier than cycle N+1.
- **Queue:** FIFO pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
- **Reset values:**
  - All outputs are 0 while reset is asserted.
  - The queue is emptied and starve_cnt=0.
  - The state is IDLE and rd_valid=0.
- **Reset mid-operation:** a write in flight is lost, and a pending rd_valid is cancelled.
- **Simultaneous events:** a push and a pop in the same cycle leave count unchanged. This applies when the queue is full.

## Structure
- **Package fb_arbiter_pkg:**
  - FB_ADDR_WIDTH=10, PANEL_W=2, ROW_W=4, CHUNK_W=4.
  - arb_state_t enum {IDLE, READ, WRITE, FORCED_WRITE}.
  - fb_write_t struct {addr, data}.
- **Sub-module fb_write_fifo:** a synchronous FIFO of fb_write_t with the full/empty/count behaviour above. The arbiter instantiates it once.

## Test plan
- **Reset and basic write:**
  - Stimulus: reset, then one wr_req with panel=2, row=5, chunk=3, data=0xDEADBEEF, rd_req=0.
  - Required: the next cycle has ram_we=1, ram_addr=0x253 and ram_wdata=0xDEADBEEF; the queue is then empty.
- **Read priority:**
  - Stimulus: rd_req held high at address 0x010, with two writes queued.
  - Required: rd_grant=1 every cycle; after 8 grants, the 9th cycle is a forced write (rd_grant=0) and starve_cnt returns to 0.
- **Read data:**
  - Stimulus: preload the RAM model so that 0x3FF holds 0x12345678, then rd_req at 0x3FF.
  - Required: rd_valid=1 and rd_data=0x12345678 exactly one cycle after rd_grant.
- **Overflow:**
  - Stimulus: hold rd_req high and issue 5 wr_req strobes in cycles before STARVE_LIMIT is reached.
  - Required: wr_full=1 after the 4th strobe; the 5th is dropped and wr_overflow=1 stays set until reset.
- **Full with simultaneous pop:**
  - Stimulus: with the queue full, rd_req=0 and wr_req=1.
  - Required: the head is written, the new entry is accepted, count stays 4 and wr_overflow stays 0.
- **Reset mid-read:**
  - Stimulus: assert reset in the cycle after rd_grant.
  - Required: rd_valid=0 immediately, the queue is empty, and the state is IDLE.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// rtl/fb_arbiter_pkg.sv - shared types and widths for the frame-buffer arbiter
package fb_arbiter_pkg;

   localparam int FB_ADDR_WIDTH = 10;
   localparam int PANEL_W       = 2;
   localparam int ROW_W         = 4;
   localparam int CHUNK_W       = 4;
   localparam int FB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FORCED_WRITE
   } arb_state_t;

   typedef struct packed {
      logic [FB_ADDR_WIDTH-1:0] addr;
      logic [FB_DATA_WIDTH-1:0] data;
   } fb_write_t;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// rtl/frame_buffer_arbiter_if.sv - USB write, scan read and RAM signals of the arbiter
interface frame_buffer_arbiter_if
   import fb_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic                     wr_req;
   logic [PANEL_W-1:0]       wr_panel_addr;
   logic [ROW_W-1:0]         wr_row_addr;
   logic [CHUNK_W-1:0]       wr_chunk_addr;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     wr_full;
   logic                     wr_overflow;
   logic                     rd_req;
   logic [FB_ADDR_WIDTH-1:0] rd_addr;
   logic                     rd_grant;
   logic                     rd_valid;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic                     ram_en;
   logic                     ram_we;
   logic [FB_ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_wdata;
   logic [DATA_WIDTH-1:0]    ram_rdata;
   arb_state_t               dbg_state;
   logic [STARVE_W-1:0]      dbg_starve_cnt;
   logic [CNT_W-1:0]         dbg_count;

   modport master (
      output wr_req, wr_panel_addr, wr_row_addr, wr_chunk_addr, wr_data,
      output rd_req, rd_addr, ram_rdata,
      input  wr_full, wr_overflow, rd_grant, rd_valid, rd_data,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      input  dbg_state, dbg_starve_cnt, dbg_count
   );

   modport slave (
      input  wr_req, wr_panel_addr, wr_row_addr, wr_chunk_addr, wr_data,
      input  rd_req, rd_addr, ram_rdata,
      output wr_full, wr_overflow, rd_grant, rd_valid, rd_data,
      output ram_en, ram_we, ram_addr, ram_wdata,
      output dbg_state, dbg_starve_cnt, dbg_count
   );

endinterface

// File: rtl/fb_write_fifo.sv
// rtl/fb_write_fifo.sv - small synchronous queue of pending chunk writes
module fb_write_fifo
   import fb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fb_write_t        push_data,
   input  logic             pop,
   output fb_write_t        head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   fb_write_t        mem_q [DEPTH];
   fb_write_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap for free since DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - shares the frame-buffer RAM between queued USB writes and scan reads
module frame_buffer_arbiter
   import fb_arbiter_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int FIFO_DEPTH   = 4,
   parameter  int STARVE_LIMIT = 8,
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1,
   localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
   input logic                  clk,
   input logic                  reset,
   frame_buffer_arbiter_if.slave bus
);

   arb_state_t          state_q, state_d, grant;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                rd_valid_q, rd_valid_d;
   logic                overflow_q, overflow_d;
   logic                push, pop;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   fb_write_t           push_entry, head;

   assign push_entry = '{addr: {bus.wr_panel_addr, bus.wr_row_addr, bus.wr_chunk_addr},
                         data: FB_DATA_WIDTH'(bus.wr_data)};

   fb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant is purely combinational; the registered state only records it.
   always_comb begin
      grant = IDLE;
      if (!reset) begin
         if (!fifo_empty && starve_q == STARVE_W'(STARVE_LIMIT)) begin
            grant = FORCED_WRITE;
         end else if (bus.rd_req) begin
            grant = READ;
         end else if (!fifo_empty) begin
            grant = WRITE;
         end
      end
      state_d = grant;
   end

   always_comb begin
      pop        = (grant == WRITE) || (grant == FORCED_WRITE);
      push       = bus.wr_req && !reset && (!fifo_full || pop);
      overflow_d = overflow_q || (bus.wr_req && !reset && !push);
      rd_valid_d = (grant == READ);
      starve_d   = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (grant == READ && starve_q != STARVE_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q   <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      bus.rd_grant  = (grant == READ);
      bus.ram_en    = (grant != IDLE);
      bus.ram_we    = pop;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (grant == READ) begin
         bus.ram_addr = bus.rd_addr;
      end else if (pop) begin
         bus.ram_addr  = head.addr;
         bus.ram_wdata = DATA_WIDTH'(head.data);
      end
      bus.rd_valid       = rd_valid_q;
      bus.rd_data        = rd_valid_q ? bus.ram_rdata : '0;
      bus.wr_full        = fifo_full;
      bus.wr_overflow    = overflow_q;
      bus.dbg_state      = state_q;
      bus.dbg_starve_cnt = starve_q;
      bus.dbg_count      = fifo_count;
   end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - randomized bench against a queue-based reference model
module tb_frame_buffer_arbiter;
   import fb_arbiter_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   frame_buffer_arbiter_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) bus ();

   frame_buffer_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;

   ent_t        mq[$];
   int          m_starve;
   bit          m_prev_grant;
   logic [31:0] m_prev_data;
   bit          m_ovf;
   arb_state_t  m_state;
   logic [31:0] m_mem   [1024];
   logic [31:0] env_mem [1024];

   logic        obs_grant, obs_we, obs_full, obs_ovf, obs_rd_valid;
   logic [9:0]  obs_addr;
   logic [31:0] obs_wdata, obs_rd_data;
   logic [3:0]  obs_starve;
   logic [2:0]  obs_count;
   logic [1:0]  obs_state;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit rst_i, input bit wr, input logic [1:0] p, input logic [3:0] r,
                       input logic [3:0] c, input logic [31:0] d, input bit rd, input logic [9:0] ra);
      int          sz;
      bit          forced, rgrant, wgrant;
      arb_state_t  kind;
      logic [9:0]  e_addr;
      logic [31:0] e_wdata;
      logic        e_en, e_we;
      @(negedge clk);
      reset             = rst_i;
      bus.wr_req        = wr;
      bus.wr_panel_addr = p;
      bus.wr_row_addr   = r;
      bus.wr_chunk_addr = c;
      bus.wr_data       = d;
      bus.rd_req        = rd;
      bus.rd_addr       = ra;
      #1;
      if (rst_i) begin
         mq.delete();
         m_starve     = 0;
         m_prev_grant = 0;
         m_ovf        = 0;
         m_state      = IDLE;
      end
      sz     = mq.size();
      forced = !rst_i && sz > 0 && m_starve == LIMIT;
      rgrant = !rst_i && !forced && rd;
      wgrant = !rst_i && (forced || (!rd && sz > 0));
      kind   = forced ? FORCED_WRITE : rgrant ? READ : wgrant ? WRITE : IDLE;

      check_val("rd_grant", bus.rd_grant, rgrant);
      check_val("ram_en", bus.ram_en, rgrant || wgrant);
      check_val("ram_we", bus.ram_we, wgrant);
      check_val("ram_addr", bus.ram_addr, rgrant ? ra : wgrant ? mq[0].a : 10'h0);
      check_val("ram_wdata", bus.ram_wdata, wgrant ? mq[0].d : 32'h0);
      check_val("rd_valid", bus.rd_valid, m_prev_grant);
      check_val("rd_data", bus.rd_data, m_prev_grant ? m_prev_data : 32'h0);
      check_val("wr_full", bus.wr_full, sz == DEPTH);
      check_val("wr_overflow", bus.wr_overflow, m_ovf);
      check_val("count", bus.dbg_count, sz);
      check_val("starve_cnt", bus.dbg_starve_cnt, m_starve);
      check_val("state", bus.dbg_state, m_state);

      obs_grant    = bus.rd_grant;
      obs_we       = bus.ram_we;
      obs_addr     = bus.ram_addr;
      obs_wdata    = bus.ram_wdata;
      obs_full     = bus.wr_full;
      obs_ovf      = bus.wr_overflow;
      obs_rd_valid = bus.rd_valid;
      obs_rd_data  = bus.rd_data;
      obs_starve   = bus.dbg_starve_cnt;
      obs_count    = bus.dbg_count;
      obs_state    = bus.dbg_state;

      m_prev_data = m_mem[ra];
      if (wgrant) begin
         m_mem[mq[0].a] = mq[0].d;
         void'(mq.pop_front());
      end
      if (!rst_i && wr) begin
         if (sz < DEPTH || wgrant) mq.push_back('{a: {p, r, c}, d: d});
         else m_ovf = 1;
      end
      if (rst_i || wgrant || sz == 0) m_starve = 0;
      else if (rgrant && m_starve < LIMIT) m_starve++;
      m_state      = kind;
      m_prev_grant = rgrant;

      e_en    = bus.ram_en;
      e_we    = bus.ram_we;
      e_addr  = bus.ram_addr;
      e_wdata = bus.ram_wdata;
      @(posedge clk);
      if (e_en && e_we) env_mem[e_addr] = e_wdata;
      else if (e_en) bus.ram_rdata = env_mem[e_addr];
      else bus.ram_rdata = $urandom();
   endtask

   task automatic idle();
      step(0, 0, 2'd0, 4'd0, 4'd0, 32'h0, 0, 10'h0);
   endtask

   task automatic do_reset();
      step(1, 0, 2'd0, 4'd0, 4'd0, 32'h0, 0, 10'h0);
   endtask

   initial begin
      int forced_idx;
      bus.wr_req        = 0;
      bus.wr_panel_addr = '0;
      bus.wr_row_addr   = '0;
      bus.wr_chunk_addr = '0;
      bus.wr_data       = '0;
      bus.rd_req        = 0;
      bus.rd_addr       = '0;
      bus.ram_rdata     = '0;
      for (int i = 0; i < 1024; i++) begin
         m_mem[i]   = $urandom();
         env_mem[i] = m_mem[i];
      end

      do_reset();
      step(0, 1, 2'd2, 4'd5, 4'd3, 32'hDEADBEEF, 0, 10'h0);
      idle();
      check_val("basic_we", obs_we, 1);
      check_val("basic_addr", obs_addr, 10'h253);
      check_val("basic_wdata", obs_wdata, 32'hDEADBEEF);
      idle();
      check_val("basic_empty", obs_count, 0);

      do_reset();
      forced_idx = -1;
      for (int i = 0; i < 12; i++) begin
         step(0, i < 2, 2'd1, 4'(i), 4'd0, $urandom(), 1, 10'h010);
         if (!obs_grant && forced_idx < 0) forced_idx = i;
         if (i == 10) check_val("starve_clear", obs_starve, 0);
      end
      check_val("forced_at", forced_idx, 9);

      do_reset();
      m_mem[10'h3FF]   = 32'h12345678;
      env_mem[10'h3FF] = 32'h12345678;
      step(0, 0, 2'd0, 4'd0, 4'd0, 32'h0, 1, 10'h3FF);
      check_val("rd_grant_3ff", obs_grant, 1);
      idle();
      check_val("rd_valid_3ff", obs_rd_valid, 1);
      check_val("rd_data_3ff", obs_rd_data, 32'h12345678);

      do_reset();
      for (int i = 0; i < 5; i++) step(0, 1, 2'd3, 4'(i), 4'd7, $urandom(), 1, 10'h020);
      check_val("ovf_full", obs_full, 1);
      step(0, 0, 2'd0, 4'd0, 4'd0, 32'h0, 1, 10'h020);
      check_val("ovf_set", obs_ovf, 1);
      for (int i = 0; i < 10; i++) idle();
      check_val("ovf_sticky", obs_ovf, 1);

      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1, 2'd0, 4'(i), 4'd1, $urandom(), 1, 10'h030);
      step(0, 1, 2'd1, 4'd9, 4'd9, 32'hCAFEF00D, 0, 10'h0);
      check_val("fullpop_we", obs_we, 1);
      idle();
      check_val("fullpop_count", obs_count, 4);
      check_val("fullpop_ovf", obs_ovf, 0);

      do_reset();
      step(0, 1, 2'd2, 4'd2, 4'd2, 32'h0BADF00D, 0, 10'h0);
      step(0, 1, 2'd2, 4'd3, 4'd2, 32'h0BADF00E, 1, 10'h111);
      step(1, 0, 2'd0, 4'd0, 4'd0, 32'h0, 1, 10'h111);
      check_val("rst_rd_valid", obs_rd_valid, 0);
      check_val("rst_count", obs_count, 0);
      check_val("rst_state", obs_state, IDLE);

      do_reset();
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(99) == 0, $urandom_range(1), 2'($urandom()), 4'($urandom()),
              4'($urandom()), $urandom(), $urandom_range(3) != 0, 10'($urandom()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
